// File: rtl/axis_step_framer.sv
// axis_step_framer: skid-buffered AXI-Stream stage that tags frame ends every NO_OF_STEPS beats
// and flags upstream delimiters that disagree with the beat count.
module axis_step_framer #(
  parameter int WIDTH = 3,
  parameter int NO_OF_STEPS = 10,
  localparam int CW = $clog2(NO_OF_STEPS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             frame_err,
  output logic [7:0]       err_count
);
  logic [CW-1:0]    in_cnt;
  logic [WIDTH-1:0] sk_data;
  logic             sk_last, sk_valid;
  logic             acc, at_end, last_tag, mismatch, load;
  assign s_ready  = !sk_valid;
  assign acc      = s_valid && s_ready;
  assign at_end   = in_cnt == CW'(NO_OF_STEPS - 1);
  assign last_tag = at_end || s_last;
  assign mismatch = acc && (s_last != at_end);
  assign load     = !m_valid || m_ready;
  // skid is only ever filled while the output is stalled, and input is blocked while it is full
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      sk_last   <= 1'b0;
      in_cnt    <= '0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      if (load) begin
        if (sk_valid) begin
          m_valid  <= 1'b1;
          m_data   <= sk_data;
          m_last   <= sk_last;
          sk_valid <= 1'b0;
        end else if (acc) begin
          m_valid <= 1'b1;
          m_data  <= s_data;
          m_last  <= last_tag;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (acc) begin
        sk_valid <= 1'b1;
        sk_data  <= s_data;
        sk_last  <= last_tag;
      end
      if (acc) in_cnt <= last_tag ? '0 : in_cnt + 1'b1;
      frame_err <= mismatch;
      if (mismatch && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_axis_step_framer.sv
// tb_axis_step_framer: directed and random stimulus with a scoreboard of expected {data, last} beats.
module tb_axis_step_framer;
  localparam int W = 3;
  localparam int N = 10;
  logic clk = 1'b0, rstn = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [W-1:0] s_data = '0;
  logic s_ready, m_valid, m_last, frame_err;
  logic [W-1:0] m_data;
  logic [7:0] err_count;
  int checks = 0, errors = 0;
  logic [W:0] q[$];
  int mcnt = 0;
  logic pend_err = 1'b0;
  logic [7:0] ecnt = '0;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [W-1:0] prev_data = '0;

  axis_step_framer #(.WIDTH(W), .NO_OF_STEPS(N)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor: handshakes seen here complete on the following rising edge
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      q.delete();
      mcnt = 0;
      pend_err = 1'b0;
      ecnt = '0;
      prev_stall = 1'b0;
    end else begin
      chk("frame_err", 32'(frame_err), 32'(pend_err));
      chk("err_count", 32'(err_count), 32'(ecnt));
      if (m_valid && prev_stall) begin
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("unexpected_beat", 32'(1), 32'(0));
        else begin
          logic [W:0] e;
          e = q.pop_front();
          chk("out_data", 32'(m_data), 32'(e[W:1]));
          chk("out_last", 32'(m_last), 32'(e[0]));
        end
      end
      pend_err = 1'b0;
      if (s_valid && s_ready) begin
        logic lt;
        lt = s_last || (mcnt == N - 1);
        q.push_back({s_data, lt});
        pend_err = s_last != (mcnt == N - 1);
        if (pend_err && ecnt != 8'hff) ecnt = ecnt + 8'd1;
        mcnt = lt ? 0 : mcnt + 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic push(input logic [W-1:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    chk("push_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(posedge clk);
      #1;
      ok = (q.size() == 0) && !m_valid;
    end
    chk("drain_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int n_acc, sent, guard;
    logic pend, fire;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    m_ready = 1'b1;
    // one aligned frame, checking single-cycle latency
    for (int i = 0; i < N; i++) begin
      push(W'(i % 8), i == N - 1);
      chk("lat_valid", 32'(m_valid), 32'd1);
      chk("lat_data", 32'(m_data), 32'(i % 8));
      chk("lat_last", 32'(m_last), 32'(i == N - 1));
    end
    drain();
    // no upstream delimiters: every tenth beat is a missing-delimiter error
    for (int i = 0; i < 3 * N; i++) push(W'(i), 1'b0);
    drain();
    chk("err_after_missing", 32'(err_count), 32'd3);
    // early delimiter on beat 4, then a clean frame
    for (int i = 0; i < 4; i++) push(W'(i + 1), i == 3);
    for (int i = 0; i < N; i++) push(W'(i), i == N - 1);
    drain();
    chk("err_after_early", 32'(err_count), 32'd4);
    // stalled output: three presented beats, only two taken
    m_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data = W'(5 + k);
      s_last = 1'b0;
      @(negedge clk);
      n_acc += int'(s_ready);
      @(posedge clk);
      #1;
    end
    chk("stall_accepted", 32'(n_acc), 32'd2);
    chk("stall_s_ready", 32'(s_ready), 32'd0);
    chk("stall_m_data", 32'(m_data), 32'd5);
    m_ready = 1'b1;
    push(W'(7), 1'b0);
    for (int i = 0; i < N - 3; i++) push(W'(i), i == N - 4);
    drain();
    // random handshakes with upstream delimiters on every tenth beat
    sent = 0;
    guard = 0;
    pend = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      if (!pend && $urandom_range(1) == 1) begin
        pend = 1'b1;
        s_data = W'($urandom);
        s_last = (sent % N) == N - 1;
      end
      s_valid = pend;
      m_ready = $urandom_range(1) == 1;
      @(negedge clk);
      fire = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        pend = 1'b0;
        sent++;
      end
      guard++;
    end
    chk("random_sent", 32'(sent), 32'd1000);
    drain();
    chk("random_err", 32'(err_count), 32'd4);
    // reset with a full skid in mid-frame
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(W'(i), 1'b0);
    m_ready = 1'b0;
    push(W'(3), 1'b0);
    s_valid = 1'b1;
    s_data = W'(4);
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_m_valid", 32'(m_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_m_valid", 32'(m_valid), 32'd0);
    chk("async_s_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      push(W'(i), i == N - 1);
      chk("post_rst_last", 32'(m_last), 32'(i == N - 1));
    end
    drain();
    chk("post_rst_err", 32'(err_count), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
